// File: rtl/audio_vol_ramp_if.sv
// Stereo sample stream between the core's audio source, the volume ramp and the I2S stage.
interface audio_vol_ramp_if #(
  parameter int AW = 16
) ();
  logic                 sample_en;
  logic signed [AW-1:0] audio_l_in;
  logic signed [AW-1:0] audio_r_in;
  logic                 out_valid;
  logic signed [AW-1:0] audio_l_out;
  logic signed [AW-1:0] audio_r_out;

  modport master (
    output sample_en, audio_l_in, audio_r_in,
    input  out_valid, audio_l_out, audio_r_out
  );

  modport slave (
    input  sample_en, audio_l_in, audio_r_in,
    output out_valid, audio_l_out, audio_r_out
  );
endinterface

// File: rtl/audio_vol_ramp.sv
// Click-free stereo attenuator: 6 dB steps from vol_att/mute, gain ramped per sample,
// fixed two-cycle sample latency.
module audio_vol_ramp #(
  parameter int AW        = 16,
  parameter int RAMP_STEP = 4
) (
  input  logic                clk_sys,
  input  logic                reset,
  input  logic [3:0]          vol_att,
  input  logic                mute,
  audio_vol_ramp_if.slave     aif,
  output logic [8:0]          gain,
  output logic                ramp_busy
);

  localparam int         PW   = AW + 10;
  localparam logic [9:0] STEP = 10'(RAMP_STEP);

  function automatic logic [8:0] target_gain(input logic m, input logic [3:0] va);
    if (m || va[3]) return 9'd0;
    return 9'd256 >> va[2:0];
  endfunction

  // Moves one step toward tgt without overshoot; 10-bit math keeps the sum from wrapping.
  function automatic logic [8:0] ramp_next(input logic [8:0] cur, input logic [8:0] tgt);
    logic [9:0] c;
    logic [9:0] t;
    logic [9:0] up;
    c  = {1'b0, cur};
    t  = {1'b0, tgt};
    up = c + STEP;
    if (c < t) return (up > t) ? tgt : up[8:0];
    if (c > t) return ((c - t) <= STEP) ? tgt : 9'(c - STEP);
    return cur;
  endfunction

  // Q1.8 rescale by arithmetic shift (floor); |gain| <= 256 keeps the result within AW bits.
  function automatic logic signed [AW-1:0] scale_trunc(input logic signed [PW-1:0] p);
    logic signed [PW-1:0] s;
    s = p >>> 8;
    return $signed(s[AW-1:0]);
  endfunction

  logic [8:0]           target;
  logic [8:0]           gain_q, gain_d;
  logic                 busy_q, busy_d;
  logic signed [PW-1:0] gain_ext;
  logic                 vld_p1_q, vld_p1_d;
  logic signed [PW-1:0] prod_l_p1_q, prod_l_p1_d;
  logic signed [PW-1:0] prod_r_p1_q, prod_r_p1_d;
  logic                 vld_p2_q, vld_p2_d;
  logic signed [AW-1:0] out_l_p2_q, out_l_p2_d;
  logic signed [AW-1:0] out_r_p2_q, out_r_p2_d;

  always_comb begin
    target   = target_gain(mute, vol_att);
    gain_ext = PW'($signed({1'b0, gain_q}));
    gain_d   = gain_q;
    if (aif.sample_en) gain_d = ramp_next(gain_q, target);
    busy_d   = (gain_d != target);

    // Stage 1: multiply by the pre-update gain
    vld_p1_d    = aif.sample_en;
    prod_l_p1_d = prod_l_p1_q;
    prod_r_p1_d = prod_r_p1_q;
    if (aif.sample_en) begin
      prod_l_p1_d = PW'(aif.audio_l_in) * gain_ext;
      prod_r_p1_d = PW'(aif.audio_r_in) * gain_ext;
    end

    // Stage 2: rescale, outputs hold between strobes
    vld_p2_d   = vld_p1_q;
    out_l_p2_d = out_l_p2_q;
    out_r_p2_d = out_r_p2_q;
    if (vld_p1_q) begin
      out_l_p2_d = scale_trunc(prod_l_p1_q);
      out_r_p2_d = scale_trunc(prod_r_p1_q);
    end
  end

  // Reset also clears the data path so the output restarts from silence.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      gain_q      <= 9'd0;
      busy_q      <= (target != 9'd0);
      vld_p1_q    <= 1'b0;
      prod_l_p1_q <= '0;
      prod_r_p1_q <= '0;
      vld_p2_q    <= 1'b0;
      out_l_p2_q  <= '0;
      out_r_p2_q  <= '0;
    end else begin
      gain_q      <= gain_d;
      busy_q      <= busy_d;
      vld_p1_q    <= vld_p1_d;
      prod_l_p1_q <= prod_l_p1_d;
      prod_r_p1_q <= prod_r_p1_d;
      vld_p2_q    <= vld_p2_d;
      out_l_p2_q  <= out_l_p2_d;
      out_r_p2_q  <= out_r_p2_d;
    end
  end

  assign gain            = gain_q;
  assign ramp_busy       = busy_q;
  assign aif.out_valid   = vld_p2_q;
  assign aif.audio_l_out = out_l_p2_q;
  assign aif.audio_r_out = out_r_p2_q;

endmodule
